// File: rtl/execute_stage_if.sv
// Bundle of the decode-to-execute inputs and the EX/MEM pipeline register outputs.
// The slave side is the execute stage; the master side is its surroundings.
interface execute_stage_if;
    logic [4:0]  inWB;
    logic [1:0]  inMEM;
    logic        inJL;
    logic [31:0] inNextInstructionAddress;
    logic [31:0] inRegA;
    logic [31:0] inRegB;
    logic [31:0] inImm;
    logic        inALUSrc;
    logic [4:0]  inShamt;
    logic        inShiftVar;
    logic [3:0]  inALUOp;
    logic [4:0]  inRegF_wreg;
    logic [1:0]  inFwdA;
    logic [1:0]  inFwdB;
    logic [31:0] inFwdMem;
    logic [31:0] inFwdWb;

    logic [4:0]  outWB;
    logic [1:0]  outMEM;
    logic        outJL;
    logic [31:0] outNextInstructionAddress;
    logic [31:0] outALUResult;
    logic [31:0] outRegB;
    logic [4:0]  outRegF_wreg;
    logic        outStall;

    modport master (
        output inWB, inMEM, inJL, inNextInstructionAddress, inRegA, inRegB, inImm,
               inALUSrc, inShamt, inShiftVar, inALUOp, inRegF_wreg, inFwdA, inFwdB,
               inFwdMem, inFwdWb,
        input  outWB, outMEM, outJL, outNextInstructionAddress, outALUResult, outRegB,
               outRegF_wreg, outStall
    );

    modport slave (
        input  inWB, inMEM, inJL, inNextInstructionAddress, inRegA, inRegB, inImm,
               inALUSrc, inShamt, inShiftVar, inALUOp, inRegF_wreg, inFwdA, inFwdB,
               inFwdMem, inFwdWb,
        output outWB, outMEM, outJL, outNextInstructionAddress, outALUResult, outRegB,
               outRegF_wreg, outStall
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, single-cycle ALU, and a 32-step MULT/DIV unit
// owning HI/LO. State changes on the falling edge and freezes under stop_debug.
module execute_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic          stop_debug,
    execute_stage_if.slave ex
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_LUI  = 4'd11,
        OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_MULT = 4'd14, OP_DIV  = 4'd15
    } aluOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdState_t;

    aluOp_t      op;
    logic [31:0] opA;
    logic [31:0] opBReg;
    logic [31:0] opB;
    logic [4:0]  shiftAmt;
    logic [31:0] aluResult;
    logic        isMulDiv;

    mdState_t    state;
    mdState_t    stateNext;
    logic [4:0]  count;
    logic [31:0] accHi;
    logic [31:0] accLo;
    logic [31:0] operand;
    logic        isDiv;
    logic        negMain;
    logic        negRem;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic        divFits;
    logic [32:0] divRem;
    logic [31:0] stepHi;
    logic [31:0] stepLo;
    logic [63:0] stepProd;
    logic [31:0] finalHi;
    logic [31:0] finalLo;

    assign op       = aluOp_t'(ex.inALUOp);
    assign isMulDiv = (op == OP_MULT) || (op == OP_DIV);

    // NOTE: every variable assigned in an always_comb gets a default first, so no path
    // through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        opA    = ex.inRegA;
        opBReg = ex.inRegB;
        case (ex.inFwdA)
            2'b01:   opA = ex.inFwdMem;
            2'b10:   opA = ex.inFwdWb;
            default: opA = ex.inRegA;
        endcase
        case (ex.inFwdB)
            2'b01:   opBReg = ex.inFwdMem;
            2'b10:   opBReg = ex.inFwdWb;
            default: opBReg = ex.inRegB;
        endcase
    end

    assign opB      = ex.inALUSrc ? ex.inImm : opBReg;
    assign shiftAmt = ex.inShiftVar ? opA[4:0] : ex.inShamt;

    always_comb begin
        aluResult = '0;
        case (op)
            OP_ADD:  aluResult = opA + opB;
            OP_SUB:  aluResult = opA - opB;
            OP_AND:  aluResult = opA & opB;
            OP_OR:   aluResult = opA | opB;
            OP_XOR:  aluResult = opA ^ opB;
            OP_NOR:  aluResult = ~(opA | opB);
            OP_SLT:  aluResult = {31'b0, $signed(opA) < $signed(opB)};
            OP_SLTU: aluResult = {31'b0, opA < opB};
            OP_SLL:  aluResult = opB << shiftAmt;
            OP_SRL:  aluResult = opB >> shiftAmt;
            OP_SRA:  aluResult = $unsigned($signed(opB) >>> shiftAmt);
            OP_LUI:  aluResult = {opB[15:0], 16'h0000};
            OP_MFHI: aluResult = hi;
            OP_MFLO: aluResult = lo;
            default: aluResult = '0;
        endcase
    end

    // One iteration of the unsigned core. MULT keeps {partial product, multiplier} in
    // accHi:accLo and shifts right; DIV keeps {remainder, quotient} and shifts left.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
        divShift = {accHi, accLo[31]};
        divFits  = divShift >= {1'b0, operand};
        divRem   = divFits ? (divShift - {1'b0, operand}) : divShift;
        if (isDiv) begin
            stepHi = divRem[31:0];
            stepLo = {accLo[30:0], divFits};
        end else begin
            stepHi = mulSum[32:1];
            stepLo = {mulSum[0], accLo[31:1]};
        end
    end

    // Sign correction on the last iteration; a zero divisor forces an all-ones quotient
    // while the remainder path naturally returns the dividend.
    always_comb begin
        stepProd = negMain ? -{stepHi, stepLo} : {stepHi, stepLo};
        finalHi  = stepProd[63:32];
        finalLo  = stepProd[31:0];
        if (isDiv) begin
            finalHi = negRem ? -stepHi : stepHi;
            if (operand == 32'd0) begin
                finalLo = 32'hFFFF_FFFF;
            end else begin
                finalLo = negMain ? -stepLo : stepLo;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (isMulDiv) stateNext = RUN;
            RUN:     if (count == 5'd31) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign ex.outStall = (state == RUN) || ((state == IDLE) && isMulDiv);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (!stop_debug) begin
            state <= stateNext;
        end
    end

    // NOTE: the iteration registers are reset along with HI/LO so that an operation
    // aborted by reset leaves no residue that a later MFHI/MFLO could observe.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (!stop_debug) begin
            case (state)
                IDLE: begin
                    if (isMulDiv) begin
                        count   <= '0;
                        accHi   <= '0;
                        accLo   <= opA[31] ? -opA : opA;
                        operand <= opB[31] ? -opB : opB;
                        isDiv   <= (op == OP_DIV);
                        negMain <= opA[31] ^ opB[31];
                        negRem  <= opA[31];
                    end
                end
                RUN: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi <= finalHi;
                        lo <= finalLo;
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM register: a stalled edge latches an all-zero bubble.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ex.outWB                     <= '0;
            ex.outMEM                    <= '0;
            ex.outJL                     <= 1'b0;
            ex.outNextInstructionAddress <= '0;
            ex.outALUResult              <= '0;
            ex.outRegB                   <= '0;
            ex.outRegF_wreg              <= '0;
        end else if (!stop_debug) begin
            if (ex.outStall) begin
                ex.outWB                     <= '0;
                ex.outMEM                    <= '0;
                ex.outJL                     <= 1'b0;
                ex.outNextInstructionAddress <= '0;
                ex.outALUResult              <= '0;
                ex.outRegB                   <= '0;
                ex.outRegF_wreg              <= '0;
            end else begin
                ex.outWB                     <= ex.inWB;
                ex.outMEM                    <= ex.inMEM;
                ex.outJL                     <= ex.inJL;
                ex.outNextInstructionAddress <= ex.inNextInstructionAddress;
                ex.outALUResult              <= aluResult;
                ex.outRegB                   <= opBReg;
                ex.outRegF_wreg              <= ex.inRegF_wreg;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage: the driver pushes one expected record
// per clock cycle from an arithmetic reference model; a monitor pops and compares.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst;
    logic stop_debug;

    execute_stage_if bus ();

    execute_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stop_debug (stop_debug),
        .ex         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wb;
        logic [1:0]  mem;
        logic        jl;
        logic [31:0] nia;
        logic [31:0] alu;
        logic [31:0] regB;
        logic [4:0]  wreg;
    } out_t;

    typedef struct {
        bit          stall;
        out_t        out;
        bit          hasMust;
        bit          mustRegB;
        logic [31:0] must;
        string       tag;
    } rec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] regA, regB, imm, fwdMem, fwdWb, nia;
        logic [1:0]  fwdA, fwdB, mem;
        logic        aluSrc, shiftVar, jl;
        logic [4:0]  shamt, wb, wreg;
    } instr_t;

    rec_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mHi      = '0;
    logic [31:0] mLo      = '0;
    out_t        curOut   = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t sampleOut();
        out_t o;
        o.wb   = bus.outWB;
        o.mem  = bus.outMEM;
        o.jl   = bus.outJL;
        o.nia  = bus.outNextInstructionAddress;
        o.alu  = bus.outALUResult;
        o.regB = bus.outRegB;
        o.wreg = bus.outRegF_wreg;
        return o;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwdSel(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return r;
    endfunction

    function automatic logic [31:0] refAlu(input instr_t i);
        logic [31:0] a, b;
        int          amt;
        a   = fwdSel(i.fwdA, i.regA, i.fwdMem, i.fwdWb);
        b   = i.aluSrc ? i.imm : fwdSel(i.fwdB, i.regB, i.fwdMem, i.fwdWb);
        amt = i.shiftVar ? int'(a % 32) : int'(i.shamt);
        case (i.op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return b << amt;
            4'd9:    return b >> amt;
            4'd10:   return $unsigned($signed(b) >>> amt);
            4'd11:   return b << 16;
            4'd12:   return mHi;
            4'd13:   return mLo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic out_t expOut(input instr_t i, input logic [31:0] alu);
        out_t o;
        o.wb   = i.wb;
        o.mem  = i.mem;
        o.jl   = i.jl;
        o.nia  = i.nia;
        o.alu  = alu;
        o.regB = fwdSel(i.fwdB, i.regB, i.fwdMem, i.fwdWb);
        o.wreg = i.wreg;
        return o;
    endfunction

    // ---------------- stimulus ----------------
    function automatic instr_t randInstr(input logic [3:0] op);
        instr_t i;
        i.op       = op;
        i.regA     = $urandom;
        i.regB     = $urandom;
        i.imm      = $urandom;
        i.fwdMem   = $urandom;
        i.fwdWb    = $urandom;
        i.nia      = $urandom;
        i.fwdA     = 2'($urandom_range(0, 3));
        i.fwdB     = 2'($urandom_range(0, 3));
        i.mem      = 2'($urandom_range(0, 3));
        i.aluSrc   = 1'($urandom_range(0, 1));
        i.shiftVar = 1'($urandom_range(0, 1));
        i.jl       = 1'($urandom_range(0, 1));
        i.shamt    = 5'($urandom_range(0, 31));
        i.wb       = 5'($urandom_range(1, 31));
        i.wreg     = 5'($urandom_range(0, 31));
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic aluSrc, input logic [31:0] imm);
        instr_t i;
        i          = randInstr(op);
        i.fwdA     = 2'd0;
        i.fwdB     = 2'd0;
        i.shiftVar = 1'b0;
        i.regA     = a;
        i.regB     = b;
        i.aluSrc   = aluSrc;
        i.imm      = imm;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        bus.inALUOp                  = i.op;
        bus.inRegA                   = i.regA;
        bus.inRegB                   = i.regB;
        bus.inImm                    = i.imm;
        bus.inFwdMem                 = i.fwdMem;
        bus.inFwdWb                  = i.fwdWb;
        bus.inNextInstructionAddress = i.nia;
        bus.inFwdA                   = i.fwdA;
        bus.inFwdB                   = i.fwdB;
        bus.inMEM                    = i.mem;
        bus.inALUSrc                 = i.aluSrc;
        bus.inShiftVar               = i.shiftVar;
        bus.inJL                     = i.jl;
        bus.inShamt                  = i.shamt;
        bus.inWB                     = i.wb;
        bus.inRegF_wreg              = i.wreg;
    endtask

    task automatic cycle(input instr_t i, input bit stop, input bit stall, input out_t o,
                         input string tag, input bit hasMust = 1'b0, input bit mustRegB = 1'b0,
                         input logic [31:0] must = '0);
        rec_t r;
        @(posedge clk);
        stop_debug = stop;
        drive(i);
        r.stall    = stall;
        r.out      = o;
        r.hasMust  = hasMust;
        r.mustRegB = mustRegB;
        r.must     = must;
        r.tag      = tag;
        sb.push_back(r);
    endtask

    task automatic issue(input instr_t i, input string tag, input bit hasMust = 1'b0,
                         input bit mustRegB = 1'b0, input logic [31:0] must = '0,
                         input int freezeAt = -1, input int freezeLen = 0, input int abortAt = -1);
        logic [31:0]        a, b, nHi, nLo;
        logic signed [63:0] p, q, rm;
        if (i.op < 4'd14) begin
            curOut = expOut(i, refAlu(i));
            cycle(i, 1'b0, 1'b0, curOut, tag, hasMust, mustRegB, must);
        end else begin
            a = fwdSel(i.fwdA, i.regA, i.fwdMem, i.fwdWb);
            b = i.aluSrc ? i.imm : fwdSel(i.fwdB, i.regB, i.fwdMem, i.fwdWb);
            if (i.op == 4'd14) begin
                p   = 64'($signed(a)) * 64'($signed(b));
                nHi = p[63:32];
                nLo = p[31:0];
            end else if (b == 32'd0) begin
                nHi = a;
                nLo = 32'hFFFF_FFFF;
            end else begin
                q   = 64'($signed(a)) / 64'($signed(b));
                rm  = 64'($signed(a)) % 64'($signed(b));
                nHi = rm[31:0];
                nLo = q[31:0];
            end
            // 1 IDLE + 32 RUN cycles with stall high, then the DONE cycle.
            for (int c = 0; c < 33; c++) begin
                if (c == abortAt) return;
                if (c == freezeAt) begin
                    for (int f = 0; f < freezeLen; f++)
                        cycle(i, 1'b1, 1'b1, curOut, {tag, " frozen"});
                end
                curOut = '0;
                cycle(i, 1'b0, 1'b1, curOut, {tag, " busy"});
            end
            curOut = expOut(i, 32'd0);
            cycle(i, 1'b0, 1'b0, curOut, {tag, " done"}, hasMust, mustRegB, must);
            mHi = nHi;
            mLo = nLo;
        end
    endtask

    task automatic doReset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check({tag, " async clear"}, 128'(sampleOut()), 128'd0);
        drive(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst    = 1'b1;
        curOut = '0;
        mHi    = '0;
        mLo    = '0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check({r.tag, " stall"}, 128'(bus.outStall), 128'(r.stall));
                @(negedge clk);
                #2;
                check({r.tag, " outputs"}, 128'(sampleOut()), 128'(r.out));
                if (r.hasMust)
                    check({r.tag, " value"}, 128'(r.mustRegB ? bus.outRegB : bus.outALUResult),
                          128'(r.must));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        instr_t i;
        rst        = 1'b0;
        stop_debug = 1'b0;
        drive(mk(4'd0, 32'd0, 32'd0, 1'b0, 32'd0));
        #3;
        check("reset outputs", 128'(sampleOut()), 128'd0);
        check("reset stall", 128'(bus.outStall), 128'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;

        issue(mk(4'd0, 32'h7FFF_FFFF, 32'd0, 1'b1, 32'd1), "add wrap", 1, 0, 32'h8000_0000);
        issue(mk(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0), "slt", 1, 0, 32'd1);
        issue(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0), "sltu", 1, 0, 32'd0);
        i = mk(4'd10, 32'd0, 32'h8000_0000, 1'b0, 32'd0);
        i.shamt = 5'd4;
        issue(i, "sra", 1, 0, 32'hF800_0000);
        issue(mk(4'd11, 32'd0, 32'd0, 1'b1, 32'h0000_1234), "lui", 1, 0, 32'h1234_0000);

        i = mk(4'd0, 32'd5, 32'd0, 1'b1, 32'd1);
        i.fwdMem = 32'd9;
        i.fwdA   = 2'b01;
        issue(i, "fwd mem A", 1, 0, 32'd10);
        i = mk(4'd0, 32'd1, 32'd2, 1'b0, 32'd0);
        i.fwdB  = 2'b10;
        i.fwdWb = 32'hAA;
        issue(i, "fwd wb B", 1, 1, 32'hAA);

        issue(mk(4'd14, -32'sd3, 32'd7, 1'b0, 32'd0), "mult -3x7");
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo mult", 1, 0, 32'hFFFF_FFEB);
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi mult", 1, 0, 32'hFFFF_FFFF);

        issue(mk(4'd15, -32'sd7, 32'd2, 1'b0, 32'd0), "div -7/2");
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo div", 1, 0, 32'hFFFF_FFFD);
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi div", 1, 0, 32'hFFFF_FFFF);

        issue(mk(4'd15, 32'd5, 32'd0, 1'b0, 32'd0), "div 5/0");
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo div0", 1, 0, 32'hFFFF_FFFF);
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi div0", 1, 0, 32'd5);

        issue(mk(4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0), "div min/-1");
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo min", 1, 0, 32'h8000_0000);
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi min", 1, 0, 32'd0);

        issue(mk(4'd15, 32'd100, 32'd7, 1'b0, 32'd0), "div freeze", 0, 0, 32'd0, 15, 10);
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo freeze", 1, 0, 32'd14);
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi freeze", 1, 0, 32'd2);

        for (int n = 0; n < 80; n++) begin
            i = randInstr(4'($urandom_range(0, 15)));
            if ((i.op < 4'd14) && ($urandom_range(0, 7) == 0))
                cycle(i, 1'b1, 1'b0, curOut, "rand frozen");
            issue(i, "rand");
        end

        issue(mk(4'd14, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0), "mult pre-reset");
        i = mk(4'd0, 32'd3, 32'd4, 1'b0, 32'd0);
        i.wb = 5'h1F;
        issue(i, "add pre-reset");
        doReset("midstream reset");
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi after reset", 1, 0, 32'd0);

        issue(mk(4'd14, 32'h0012_3456, 32'h0054_3210, 1'b0, 32'd0), "mult pre-abort");
        issue(mk(4'd15, 32'd1000, 32'd3, 1'b0, 32'd0), "div abort", 0, 0, 32'd0, -1, 0, 12);
        doReset("abort reset");
        issue(mk(4'd12, 32'd0, 32'd0, 1'b0, 32'd0), "mfhi after abort", 1, 0, 32'd0);
        issue(mk(4'd13, 32'd0, 32'd0, 1'b0, 32'd0), "mflo after abort", 1, 0, 32'd0);
        issue(mk(4'd0, 32'd1, 32'd2, 1'b0, 32'd0), "add after abort", 1, 0, 32'd3);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        check("scoreboard drained", 128'(sb.size()), 128'd0);
        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
